// File: rtl/cram_read_arbiter_if.sv
// One AXI4 read port (AR + R channels). The arbiter takes two slave-side
// instances (core, MMU) and drives one master-side instance toward the CRAM.
interface cram_read_arbiter_if #(
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W_C = 32
);
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W_C-1:0] rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
    output arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
    input  arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/cram_read_arbiter.sv
// Two-master, one-slave AXI4 read arbiter for the CRAM port; one burst in flight.
// Define CRAM_ARB_RR_EN for round-robin tie-breaking; otherwise master 0 wins ties.
module cram_read_arbiter #(
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W_C = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cram_read_arbiter_if.slave   s0,
  cram_read_arbiter_if.slave   s1,
  cram_read_arbiter_if.master  m,
  output logic                 owner,
  output logic                 busy,
  output logic                 burst_err
);

  localparam int RW = ID_W + DATA_W_C + 3;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
  } ar_t;

  state_t      state_q, state_d;
  ar_t         ar_q, ar_d, s0_ar, s1_ar;
  logic        owner_q, owner_d;
  logic        arvalid_q, arvalid_d;
  logic        err_q, err_d;
  logic [8:0]  beat_q, beat_d;
  logic [8:0]  beat_inc, len_p1;
  logic        grant1, grant_any, r_hs;
  logic [RW-1:0] r_pay;

  assign s0_ar = {s0.arid, s0.araddr, s0.arlen, s0.arsize, s0.arburst,
                  s0.arlock, s0.arcache, s0.arprot, s0.arqos};
  assign s1_ar = {s1.arid, s1.araddr, s1.arlen, s1.arsize, s1.arburst,
                  s1.arlock, s1.arcache, s1.arprot, s1.arqos};

`ifdef CRAM_ARB_RR_EN
  logic rr_q, rr_d;
  assign grant1 = s1.arvalid & (~s0.arvalid | rr_q);
`else
  assign grant1 = s1.arvalid & ~s0.arvalid;
`endif

  // rst gates the grant so arready stays low while reset is held
  assign grant_any  = (state_q == IDLE) & ~rst & (s0.arvalid | s1.arvalid);
  assign s0.arready = grant_any & ~grant1;
  assign s1.arready = grant_any & grant1;

  assign m.arid    = ar_q.id;
  assign m.araddr  = ar_q.addr;
  assign m.arlen   = ar_q.len;
  assign m.arsize  = ar_q.size;
  assign m.arburst = ar_q.burst;
  assign m.arlock  = ar_q.lock;
  assign m.arcache = ar_q.cache;
  assign m.arprot  = ar_q.prot;
  assign m.arqos   = ar_q.qos;
  assign m.arvalid = arvalid_q;

  assign r_pay = {m.rid, m.rdata, m.rresp, m.rlast};

  always_comb begin
    {s0.rid, s0.rdata, s0.rresp, s0.rlast} = '0;
    {s1.rid, s1.rdata, s1.rresp, s1.rlast} = '0;
    s0.rvalid = 1'b0;
    s1.rvalid = 1'b0;
    m.rready  = 1'b0;
    if (state_q == DATA) begin
      if (owner_q) begin
        {s1.rid, s1.rdata, s1.rresp, s1.rlast} = r_pay;
        s1.rvalid = m.rvalid;
        m.rready  = s1.rready;
      end else begin
        {s0.rid, s0.rdata, s0.rresp, s0.rlast} = r_pay;
        s0.rvalid = m.rvalid;
        m.rready  = s0.rready;
      end
    end
  end

  assign r_hs     = m.rvalid & m.rready;
  assign beat_inc = beat_q + 9'd1;
  assign len_p1   = {1'b0, ar_q.len} + 9'd1;

  always_comb begin
    state_d   = state_q;
    ar_d      = ar_q;
    owner_d   = owner_q;
    arvalid_d = arvalid_q;
    beat_d    = beat_q;
    err_d     = err_q;
`ifdef CRAM_ARB_RR_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          ar_d      = grant1 ? s1_ar : s0_ar;
          owner_d   = grant1;
          beat_d    = '0;
          arvalid_d = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (m.arready) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          // saturate so a runaway burst cannot wrap back to a matching count
          if (beat_q != 9'h1FF) beat_d = beat_inc;
          if (m.rlast) begin
            state_d = IDLE;
            if (beat_inc != len_p1) err_d = 1'b1;
`ifdef CRAM_ARB_RR_EN
            rr_d = ~owner_q;
`endif
          end else if (beat_inc == len_p1) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ar_q      <= '0;
      owner_q   <= 1'b0;
      arvalid_q <= 1'b0;
      beat_q    <= '0;
      err_q     <= 1'b0;
`ifdef CRAM_ARB_RR_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ar_q      <= ar_d;
      owner_q   <= owner_d;
      arvalid_q <= arvalid_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
`ifdef CRAM_ARB_RR_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
  assign burst_err = err_q;

endmodule

// File: tb/tb_cram_read_arbiter.sv
// Self-checking bench for cram_read_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of grants and beat delivery.
module tb_cram_read_arbiter;
  localparam int ID_W = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic owner, busy, burst_err;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  cram_read_arbiter_if #(.ID_W(ID_W), .ADDR_W(AW), .DATA_W_C(DW)) s0_if ();
  cram_read_arbiter_if #(.ID_W(ID_W), .ADDR_W(AW), .DATA_W_C(DW)) s1_if ();
  cram_read_arbiter_if #(.ID_W(ID_W), .ADDR_W(AW), .DATA_W_C(DW)) m_if ();

  cram_read_arbiter #(.ID_W(ID_W), .ADDR_W(AW), .DATA_W_C(DW)) dut (
    .clk(clk), .rst(rst), .s0(s0_if), .s1(s1_if), .m(m_if),
    .owner(owner), .busy(busy), .burst_err(burst_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs;
    s0_if.arvalid = 1'b0; s0_if.arid = '0; s0_if.araddr = '0; s0_if.arlen = '0;
    s0_if.arsize = '0; s0_if.arburst = '0; s0_if.arlock = 1'b0; s0_if.arcache = '0;
    s0_if.arprot = '0; s0_if.arqos = '0; s0_if.rready = 1'b1;
    s1_if.arvalid = 1'b0; s1_if.arid = '0; s1_if.araddr = '0; s1_if.arlen = '0;
    s1_if.arsize = '0; s1_if.arburst = '0; s1_if.arlock = 1'b0; s1_if.arcache = '0;
    s1_if.arprot = '0; s1_if.arqos = '0; s1_if.rready = 1'b1;
    m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = '0; m_if.rid = '0;
    m_if.rresp = '0; m_if.rlast = 1'b0;
  endtask

  task automatic set_ar(input int mi, input logic [ID_W-1:0] id,
                        input logic [AW-1:0] addr, input logic [7:0] len);
    if (mi == 0) begin
      s0_if.arvalid = 1'b1; s0_if.arid = id; s0_if.araddr = addr; s0_if.arlen = len;
      s0_if.arsize = 3'd2; s0_if.arburst = 2'b01; s0_if.arcache = 4'hF;
      s0_if.arprot = 3'd6; s0_if.arqos = 4'h4;
    end else begin
      s1_if.arvalid = 1'b1; s1_if.arid = id; s1_if.araddr = addr; s1_if.arlen = len;
      s1_if.arsize = 3'd2; s1_if.arburst = 2'b01; s1_if.arcache = 4'h2;
      s1_if.arprot = 3'd1; s1_if.arqos = 4'h9;
    end
  endtask

  task automatic drop_ar(input int mi);
    if (mi == 0) s0_if.arvalid = 1'b0;
    else         s1_if.arvalid = 1'b0;
  endtask

  task automatic set_rready(input int mi, input logic v);
    if (mi == 0) s0_if.rready = v;
    else         s1_if.rready = v;
  endtask

  // {arready, rvalid, rlast, rresp, rid, rdata} as seen by master mi
  function automatic logic [DW+ID_W+4:0] m_side(input int mi);
    if (mi == 0)
      return {s0_if.arready, s0_if.rvalid, s0_if.rlast, s0_if.rresp, s0_if.rid, s0_if.rdata};
    return {s1_if.arready, s1_if.rvalid, s1_if.rlast, s1_if.rresp, s1_if.rid, s1_if.rdata};
  endfunction

  // Accepts the AR in the current ADDR cycle and returns nbeats beats, last one flagged.
  task automatic auto_burst(input int nbeats);
    m_if.arready = 1'b1;
    step;
    m_if.arready = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      m_if.rvalid = 1'b1; m_if.rdata = 32'h5500 + 32'(i); m_if.rlast = (i == nbeats - 1);
      step;
    end
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs;
    #1 rst = 1'b1;
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs;
    s0_if.arvalid = 1'b1; s1_if.arvalid = 1'b1;
    #1;
    vec_cnt++;
    if ({s0_if.arready, s1_if.arready, m_if.arvalid, m_if.rready, s0_if.rvalid, s1_if.rvalid} !== 6'b0) begin
      err_cnt++;
      $display("FAIL reset_handshakes: got %b expected 000000",
               {s0_if.arready, s1_if.arready, m_if.arvalid, m_if.rready, s0_if.rvalid, s1_if.rvalid});
    end
    vec_cnt++;
    if ({owner, busy, burst_err} !== 3'b000) begin
      err_cnt++; $display("FAIL reset_status: got %b expected 000", {owner, busy, burst_err});
    end
    vec_cnt++;
    if ({m_if.arid, m_if.araddr, m_if.arlen, m_if.arprot} !== '0) begin
      err_cnt++; $display("FAIL reset_ar_payload: got addr %h len %h expected 0", m_if.araddr, m_if.arlen);
    end
    vec_cnt++;
    if ({s0_if.rdata, s1_if.rdata, s0_if.rid, s1_if.rlast} !== '0) begin
      err_cnt++; $display("FAIL reset_r_payload: got %h/%h expected 0", s0_if.rdata, s1_if.rdata);
    end
    s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b0;
    step;
    rst = 1'b0;
    step;
  endtask

  task automatic test_single;
    set_ar(1, 4'd2, 32'h0000_0100, 8'd3);
    #1;
    vec_cnt++;
    if ({s1_if.arready, s0_if.arready, m_if.arvalid} !== 3'b100) begin
      err_cnt++; $display("FAIL single_grant: got %b expected 100", {s1_if.arready, s0_if.arready, m_if.arvalid});
    end
    step;
    drop_ar(1);
    #1;
    vec_cnt++;
    if ({m_if.arvalid, m_if.arid, m_if.araddr, m_if.arlen, m_if.arprot, owner, s1_if.arready} !==
        {1'b1, 4'd2, 32'h100, 8'd3, 3'd1, 1'b1, 1'b0}) begin
      err_cnt++; $display("FAIL single_ar: got v %b addr %h len %h owner %b expected 1/100/3/1",
                          m_if.arvalid, m_if.araddr, m_if.arlen, owner);
    end
    step;
    #1;
    vec_cnt++;
    if ({m_if.arvalid, m_if.araddr} !== {1'b1, 32'h100}) begin
      err_cnt++; $display("FAIL single_ar_hold: got v %b addr %h expected 1/100", m_if.arvalid, m_if.araddr);
    end
    step;
    auto_ar_then_beats_single();
  endtask

  task automatic auto_ar_then_beats_single;
    m_if.arready = 1'b1;
    step;
    m_if.arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_if.rvalid = 1'b1; m_if.rdata = 32'hA0 + 32'(i); m_if.rid = 4'd2; m_if.rlast = (i == 3);
      #1;
      vec_cnt++;
      if ({s1_if.rvalid, s1_if.rdata, s1_if.rid, s1_if.rlast, s0_if.rvalid, m_if.rready} !==
          {1'b1, 32'hA0 + 32'(i), 4'd2, (i == 3), 1'b0, 1'b1}) begin
        err_cnt++; $display("FAIL single_beat%0d: got v %b data %h last %b s0v %b expected 1/%h/%b/0",
                            i, s1_if.rvalid, s1_if.rdata, s1_if.rlast, s0_if.rvalid, 32'hA0 + 32'(i), (i == 3));
      end
      step;
    end
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    #1;
    vec_cnt++;
    if ({busy, burst_err, s0_if.rvalid} !== 3'b000) begin
      err_cnt++; $display("FAIL single_done: got busy %b err %b expected 0/0", busy, burst_err);
    end
  endtask

  task automatic test_tie;
    logic [2:0] exp_order;
`ifdef CRAM_ARB_RR_EN
    exp_order = 3'b010;
`else
    exp_order = 3'b000;
`endif
    do_reset;
    set_ar(0, 4'd1, 32'h400, 8'd0);
    set_ar(1, 4'd2, 32'h500, 8'd0);
    for (int b = 0; b < 3; b++) begin
      #1;
      vec_cnt++;
      if ({s1_if.arready, s0_if.arready} !== (exp_order[b] ? 2'b10 : 2'b01)) begin
        err_cnt++; $display("FAIL tie_grant%0d: got s1/s0 arready %b%b expected master %0d",
                            b, s1_if.arready, s0_if.arready, exp_order[b]);
      end
      step;
      #1;
      vec_cnt++;
      if ({m_if.araddr, s1_if.arready, s0_if.arready} !== {(exp_order[b] ? 32'h500 : 32'h400), 2'b00}) begin
        err_cnt++; $display("FAIL tie_addr%0d: got %h expected %h", b, m_if.araddr,
                            (exp_order[b] ? 32'h500 : 32'h400));
      end
      auto_burst(1);
    end
    drop_ar(0); drop_ar(1);
    step;
  endtask

  task automatic test_backpressure;
    int  k;
    logic rr0;
    set_ar(0, 4'd1, 32'h200, 8'd7);
    step;
    drop_ar(0);
    m_if.arready = 1'b1;
    step;
    m_if.arready = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 8; cyc++) begin
      rr0 = !(cyc >= 2 && cyc <= 4);
      s0_if.rready = rr0;
      m_if.rvalid = 1'b1; m_if.rdata = 32'hB0 + 32'(k); m_if.rid = 4'd1; m_if.rlast = (k == 7);
      #1;
      vec_cnt++;
      if ({m_if.rready, s0_if.rvalid} !== {rr0, 1'b1}) begin
        err_cnt++; $display("FAIL bp_rready_c%0d: got m_rready %b s0_rvalid %b expected %b/1",
                            cyc, m_if.rready, s0_if.rvalid, rr0);
      end
      if (rr0) begin
        vec_cnt++;
        if ({s0_if.rdata, s0_if.rlast} !== {32'hB0 + 32'(k), (k == 7)}) begin
          err_cnt++; $display("FAIL bp_beat%0d: got %h last %b expected %h", k, s0_if.rdata, s0_if.rlast, 32'hB0 + 32'(k));
        end
        k++;
      end
      step;
    end
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0; s0_if.rready = 1'b1;
    #1;
    vec_cnt++;
    if (k != 8 || busy !== 1'b0 || burst_err !== 1'b0) begin
      err_cnt++; $display("FAIL bp_done: got beats %0d busy %b err %b expected 8/0/0", k, busy, burst_err);
    end
  endtask

  task automatic test_mismatch;
    set_ar(0, 4'd3, 32'h600, 8'd3);
    step;
    drop_ar(0);
    m_if.arready = 1'b1;
    step;
    m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rdata = 32'hC0; m_if.rlast = 1'b0;
    step;
    m_if.rdata = 32'hC1; m_if.rlast = 1'b1;
    #1;
    vec_cnt++;
    if ({burst_err, busy} !== 2'b01) begin
      err_cnt++; $display("FAIL mm_pre: got err %b busy %b expected 0/1", burst_err, busy);
    end
    step;
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    #1;
    vec_cnt++;
    if ({burst_err, busy} !== 2'b10) begin
      err_cnt++; $display("FAIL mm_flag: got err %b busy %b expected 1/0", burst_err, busy);
    end
    set_ar(1, 4'd4, 32'h700, 8'd0);
    #1;
    vec_cnt++;
    if (s1_if.arready !== 1'b1) begin
      err_cnt++; $display("FAIL mm_next_grant: got %b expected 1", s1_if.arready);
    end
    step;
    drop_ar(1);
    m_if.arready = 1'b1;
    step;
    m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rdata = 32'hD0; m_if.rid = 4'd4; m_if.rlast = 1'b1;
    #1;
    vec_cnt++;
    if ({s1_if.rvalid, s1_if.rdata, s1_if.rid, s1_if.rlast} !== {1'b1, 32'hD0, 4'd4, 1'b1}) begin
      err_cnt++; $display("FAIL mm_next_beat: got v %b data %h id %h expected 1/d0/4", s1_if.rvalid, s1_if.rdata, s1_if.rid);
    end
    step;
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    #1;
    vec_cnt++;
    if ({burst_err, busy} !== 2'b10) begin
      err_cnt++; $display("FAIL mm_sticky: got err %b busy %b expected 1/0", burst_err, busy);
    end
  endtask

  task automatic test_reset_mid_burst;
    set_ar(0, 4'd5, 32'h800, 8'd3);
    step;
    drop_ar(0);
    m_if.arready = 1'b1;
    step;
    m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rdata = 32'hE0;
    step;
    m_if.rdata = 32'hE1;
    set_ar(0, 4'd6, 32'h900, 8'd0);
    #1 rst = 1'b1;
    #1;
    vec_cnt++;
    if ({s0_if.arready, s1_if.arready, m_if.arvalid, m_if.rready, s0_if.rvalid, s1_if.rvalid} !== 6'b0) begin
      err_cnt++; $display("FAIL rst_mid_hs: got %b expected 000000",
                          {s0_if.arready, s1_if.arready, m_if.arvalid, m_if.rready, s0_if.rvalid, s1_if.rvalid});
    end
    vec_cnt++;
    if ({busy, burst_err} !== 2'b00) begin
      err_cnt++; $display("FAIL rst_mid_status: got busy %b err %b expected 0/0", busy, burst_err);
    end
    m_if.rvalid = 1'b0;
    step;
    rst = 1'b0;
    #1;
    vec_cnt++;
    if ({s0_if.arready, s1_if.arready} !== 2'b10) begin
      err_cnt++; $display("FAIL rst_release_grant: got s0/s1 %b%b expected 10", s0_if.arready, s1_if.arready);
    end
    step;
    drop_ar(0);
    #1;
    vec_cnt++;
    if ({m_if.arvalid, m_if.araddr, m_if.arid} !== {1'b1, 32'h900, 4'd6}) begin
      err_cnt++; $display("FAIL rst_release_ar: got v %b addr %h expected 1/900", m_if.arvalid, m_if.araddr);
    end
    auto_burst(1);
  endtask

  task automatic test_overflow;
    set_ar(1, 4'd7, 32'hA00, 8'd0);
    step;
    drop_ar(1);
    m_if.arready = 1'b1;
    step;
    m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rdata = 32'hF0; m_if.rid = 4'd7; m_if.rlast = 1'b0;
    #1;
    vec_cnt++;
    if ({burst_err, busy} !== 2'b01) begin
      err_cnt++; $display("FAIL ovf_pre: got err %b busy %b expected 0/1", burst_err, busy);
    end
    step;
    m_if.rdata = 32'hF1; m_if.rlast = 1'b1;
    #1;
    vec_cnt++;
    if ({burst_err, busy, s1_if.rvalid, s1_if.rdata, m_if.rready} !== {1'b1, 1'b1, 1'b1, 32'hF1, 1'b1}) begin
      err_cnt++; $display("FAIL ovf_flag: got err %b busy %b v %b data %h expected 1/1/1/f1",
                          burst_err, busy, s1_if.rvalid, s1_if.rdata);
    end
    step;
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    #1;
    vec_cnt++;
    if ({burst_err, busy} !== 2'b10) begin
      err_cnt++; $display("FAIL ovf_done: got err %b busy %b expected 1/0", burst_err, busy);
    end
  endtask

  task automatic test_back_to_back;
    set_ar(0, 4'd1, 32'hB00, 8'd1);
    step;
    drop_ar(0);
    m_if.arready = 1'b1;
    step;
    m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rdata = 32'h10; m_if.rlast = 1'b0;
    step;
    m_if.rdata = 32'h11; m_if.rlast = 1'b1;
    set_ar(0, 4'd2, 32'hC00, 8'd0);
    #1;
    vec_cnt++;
    if ({s0_if.arready, m_if.rready} !== 2'b01) begin
      err_cnt++; $display("FAIL b2b_t0: got arready %b rready %b expected 0/1", s0_if.arready, m_if.rready);
    end
    step;
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    #1;
    vec_cnt++;
    if ({s0_if.arready, m_if.arvalid, busy} !== 3'b100) begin
      err_cnt++; $display("FAIL b2b_t1: got arready %b arvalid %b busy %b expected 1/0/0",
                          s0_if.arready, m_if.arvalid, busy);
    end
    step;
    drop_ar(0);
    #1;
    vec_cnt++;
    if ({m_if.arvalid, m_if.araddr} !== {1'b1, 32'hC00}) begin
      err_cnt++; $display("FAIL b2b_t2: got arvalid %b addr %h expected 1/c00", m_if.arvalid, m_if.araddr);
    end
    auto_burst(1);
  endtask

  task automatic test_random;
    logic            pend [2];
    logic [ID_W-1:0] rid  [2];
    logic [AW-1:0]   radr [2];
    logic [7:0]      rlen [2];
    logic            ptr;
    int              w, k, n, o;
    logic            rv, rr, orr, lst;
    logic [DW-1:0]   dat;
    logic [1:0]      rsp;
    do_reset;
    ptr = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int b = 0; b < 40; b++) begin
      for (int mi = 0; mi < 2; mi++) begin
        if (!pend[mi] && $urandom_range(0, 2) != 0) begin
          pend[mi] = 1'b1; rid[mi] = ID_W'($urandom); radr[mi] = $urandom;
          rlen[mi] = 8'($urandom_range(0, 4));
          set_ar(mi, rid[mi], radr[mi], rlen[mi]);
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1'b1; rid[0] = 4'd9; radr[0] = 32'h1234; rlen[0] = 8'd1;
        set_ar(0, rid[0], radr[0], rlen[0]);
      end
      if (pend[0] && pend[1]) begin
`ifdef CRAM_ARB_RR_EN
        w = int'(ptr);
`else
        w = 0;
`endif
      end else begin
        w = pend[1] ? 1 : 0;
      end
      o = 1 - w;
      #1;
      vec_cnt++;
      if ({s1_if.arready, s0_if.arready} !== (w == 1 ? 2'b10 : 2'b01)) begin
        err_cnt++; $display("FAIL rnd_grant_b%0d: got s1/s0 %b%b expected master %0d", b, s1_if.arready, s0_if.arready, w);
      end
      step;
      drop_ar(w);
      pend[w] = 1'b0;
      n = $urandom_range(0, 2);
      for (int d = 0; d <= n; d++) begin
        m_if.arready = (d == n);
        #1;
        vec_cnt++;
        if ({m_if.arvalid, m_if.arid, m_if.araddr, m_if.arlen} !== {1'b1, rid[w], radr[w], rlen[w]}) begin
          err_cnt++; $display("FAIL rnd_ar_b%0d: got v %b addr %h len %h expected 1/%h/%h",
                              b, m_if.arvalid, m_if.araddr, m_if.arlen, radr[w], rlen[w]);
        end
        step;
      end
      m_if.arready = 1'b0;
      k = 0;
      for (int cyc = 0; cyc < 64 && k <= int'(rlen[w]); cyc++) begin
        rv = ($urandom_range(0, 3) != 0);
        rr = ($urandom_range(0, 3) != 0);
        orr = 1'($urandom);
        dat = $urandom; rsp = 2'($urandom); lst = (k == int'(rlen[w]));
        set_rready(w, rr); set_rready(o, orr);
        m_if.rvalid = rv; m_if.rdata = dat; m_if.rid = rid[w]; m_if.rresp = rsp; m_if.rlast = lst;
        #1;
        vec_cnt++;
        if ({m_side(w), m_side(o)[DW+ID_W+4:DW+ID_W+3], m_if.rready} !==
            {1'b0, rv, lst, rsp, rid[w], dat, 2'b00, rr}) begin
          err_cnt++; $display("FAIL rnd_r_b%0d_k%0d: got owner %h other %b rready %b expected v %b data %h rready %b",
                              b, k, m_side(w), m_side(o)[DW+ID_W+4:DW+ID_W+3], m_if.rready, rv, dat, rr);
        end
        if (rv && rr) k++;
        step;
      end
      m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
      set_rready(0, 1'b1); set_rready(1, 1'b1);
      #1;
      vec_cnt++;
      if ({busy, burst_err, owner} !== {1'b0, 1'b0, w[0]}) begin
        err_cnt++; $display("FAIL rnd_done_b%0d: got busy %b err %b owner %b expected 0/0/%0d", b, busy, burst_err, owner, w);
      end
      ptr = ~w[0];
    end
    drop_ar(0); drop_ar(1);
    step;
  endtask

  initial begin
    test_reset;
    test_single;
    test_tie;
    test_backpressure;
    test_mismatch;
    test_reset_mid_burst;
    test_overflow;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
